multi_segment_scan: RTL and testbench

//  Time-multiplexed driver for an N-digit 7-segment display sharing one segment bus.

---
 rtl/segment_pkg.sv | 45 ++++
 rtl/single_segment.sv | 66 ++++++
 rtl/multi_segment_scan.sv | 126 ++++++++++++
 tb/tb_multi_segment_scan.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/segment_pkg.sv
// Shared constants and nibble-to-glyph decoders for 7-segment displays.
// Glyph bit order is g..a (bit 6 = g, bit 0 = a).
package segment_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Digit index width, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hexadecimal glyphs 0-9, A, b, C, d, E, F
  function automatic logic [6:0] int_base16_to_segment(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Decimal glyphs 0-9; out-of-range nibbles are replaced by the caller
  function automatic logic [6:0] int_base10_to_segment(input logic [3:0] nib);
    logic [6:0] seg;
    if (nib > 4'd9) seg = SEG_BLANK;
    else            seg = int_base16_to_segment(nib);
    return seg;
  endfunction

endpackage

// File: rtl/single_segment.sv
// Decodes the currently selected nibble, applies dash substitution, leading-zero
// and global blanking plus pin polarity, and registers the result.
module single_segment
  import segment_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned BASE_10    = 1,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          nibble_i,
  input  logic                dp_i,
  input  logic [N_DIGITS-1:0] sel_i,
  input  logic                lead_zero_i,
  input  logic                lzb_en_i,
  input  logic                blank_i,
  output logic [6:0]          segment_o,
  output logic                seg_dp_o,
  output logic [N_DIGITS-1:0] digit_en_o
);

  localparam logic POL = (ACTIVE_LOW != 0);

  logic [6:0]          glyph;
  logic [6:0]          seg_d, seg_q;
  logic                dp_d, dp_q;
  logic [N_DIGITS-1:0] en_d, en_q;

  // Logical glyph selection, then inversion to pin level
  always_comb begin
    glyph = SEG_BLANK;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    en_d  = '0;
    if (BASE_10 != 0) glyph = (nibble_i > 4'd9) ? SEG_DASH : int_base10_to_segment(nibble_i);
    else              glyph = int_base16_to_segment(nibble_i);
    if (lzb_en_i && lead_zero_i) glyph = SEG_BLANK;
    if (!blank_i) begin
      seg_d = glyph;
      dp_d  = dp_i;
      en_d  = sel_i;
    end
    seg_d = seg_d ^ {7{POL}};
    dp_d  = dp_d ^ POL;
    en_d  = en_d ^ {N_DIGITS{POL}};
  end

  // Pin registers; reset drives the inactive level for the chosen polarity
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_BLANK ^ {7{POL}};
      dp_q  <= POL;
      en_q  <= {N_DIGITS{POL}};
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      en_q  <= en_d;
    end
  end

  assign segment_o  = seg_q;
  assign seg_dp_o   = dp_q;
  assign digit_en_o = en_q;

endmodule

// File: rtl/multi_segment_scan.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned value updates.
module multi_segment_scan
  import segment_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned BASE_10     = 1,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  lzb_en,
  input  logic                  blank,
  output logic [6:0]            segment,
  output logic                  seg_dp,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  frame_start
);

  localparam int unsigned IDX_W = idx_width(N_DIGITS);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned VAL_W = 4 * N_DIGITS;

  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [IDX_W-1:0]    idx_d, idx_q;
  logic [VAL_W-1:0]    shown_d, shown_q, pend_d, pend_q;
  logic [N_DIGITS-1:0] shown_dp_d, shown_dp_q, pend_dp_d, pend_dp_q;
  logic                pend_flag_d, pend_flag_q;
  logic                frame_start_d, frame_start_q;
  logic                tick, wrap;

  logic [3:0]          mux_nib;
  logic                mux_dp;
  logic [VAL_W-1:0]    upper;
  logic                lead_zero;
  logic [N_DIGITS-1:0] digit_sel;

  // Scan counter, digit index and double-buffered display value
  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    shown_d       = shown_q;
    shown_dp_d    = shown_dp_q;
    pend_d        = pend_q;
    pend_dp_d     = pend_dp_q;
    pend_flag_d   = pend_flag_q;
    tick          = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    wrap          = tick && (idx_q == IDX_W'(N_DIGITS - 1));
    frame_start_d = (idx_q == '0) && (cnt_q == '0);
    if (tick) begin
      cnt_d = '0;
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    if (wrap) begin
      // Frame boundary: a same-cycle load bypasses the pending buffer
      pend_flag_d = 1'b0;
      if (load) begin
        shown_d    = value;
        shown_dp_d = dp;
      end else if (pend_flag_q) begin
        shown_d    = pend_q;
        shown_dp_d = pend_dp_q;
      end
    end else if (load) begin
      pend_d      = value;
      pend_dp_d   = dp;
      pend_flag_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shown_q       <= '0;
      shown_dp_q    <= '0;
      pend_q        <= '0;
      pend_dp_q     <= '0;
      pend_flag_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shown_q       <= shown_d;
      shown_dp_q    <= shown_dp_d;
      pend_q        <= pend_d;
      pend_dp_q     <= pend_dp_d;
      pend_flag_q   <= pend_flag_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Select the lit digit's nibble and decide whether it is a leading zero
  always_comb begin
    mux_nib   = 4'(shown_q >> {idx_q, 2'b00});
    mux_dp    = 1'(shown_dp_q >> idx_q);
    upper     = shown_q >> {idx_q, 2'b00};
    lead_zero = (idx_q != '0) && (upper == '0);
    digit_sel = N_DIGITS'(1) << idx_q;
  end

  single_segment #(
    .N_DIGITS   (N_DIGITS),
    .BASE_10    (BASE_10),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_seg (
    .clk         (clk),
    .reset       (reset),
    .nibble_i    (mux_nib),
    .dp_i        (mux_dp),
    .sel_i       (digit_sel),
    .lead_zero_i (lead_zero),
    .lzb_en_i    (lzb_en),
    .blank_i     (blank),
    .segment_o   (segment),
    .seg_dp_o    (seg_dp),
    .digit_en_o  (digit_en)
  );

  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_multi_segment_scan.sv
// Bench for multi_segment_scan: hex, decimal and active-low instances share stimulus
// and are checked every cycle against a frame/time based reference model.
module tb_multi_segment_scan;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;
  localparam logic [12:0] AL_MASK = 13'b1111111_1_1111_0;

  logic        clk = 1'b0;
  logic        reset, load, lzb_en, blank;
  logic [15:0] value;
  logic [3:0]  dp;

  logic [6:0]  seg_h, seg_d, seg_a;
  logic        dp_h, dp_d, dp_a;
  logic [3:0]  en_h, en_d, en_a;
  logic        fs_h, fs_d, fs_a;

  int checks = 0;
  int errors = 0;
  int k = 0;

  typedef struct {
    int          e;
    logic [15:0] v;
    logic [3:0]  d;
  } ld_t;
  ld_t lq[$];

  always #5 clk = ~clk;

  multi_segment_scan #(.N_DIGITS(ND), .BASE_10(0), .REFRESH_DIV(RD), .ACTIVE_LOW(0)) u_hex (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .lzb_en(lzb_en),
    .blank(blank), .segment(seg_h), .seg_dp(dp_h), .digit_en(en_h), .frame_start(fs_h));

  multi_segment_scan #(.N_DIGITS(ND), .BASE_10(1), .REFRESH_DIV(RD), .ACTIVE_LOW(0)) u_dec (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .lzb_en(lzb_en),
    .blank(blank), .segment(seg_d), .seg_dp(dp_d), .digit_en(en_d), .frame_start(fs_d));

  multi_segment_scan #(.N_DIGITS(ND), .BASE_10(0), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) u_al (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .lzb_en(lzb_en),
    .blank(blank), .segment(seg_a), .seg_dp(dp_a), .digit_en(en_a), .frame_start(fs_a));

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  // Expected {segment, seg_dp, digit_en, frame_start} at logical level for edge kk.
  // The shown value in frame f is the last load whose frame index is below f.
  function automatic logic [12:0] model(input bit rst, input int kk, input bit blk,
                                        input bit lz, input bit dec);
    logic [15:0] v, sh;
    logic [3:0]  d, dsh, nib;
    logic [6:0]  seg;
    logic        fs;
    int          f, idx;
    if (rst) return 13'h0;
    f   = kk / FR;
    idx = (kk / RD) % ND;
    v   = '0;
    d   = '0;
    foreach (lq[i]) if (lq[i].e / FR < f) begin v = lq[i].v; d = lq[i].d; end
    sh  = v >> (4 * idx);
    nib = sh[3:0];
    dsh = d >> idx;
    seg = (dec && nib > 4'd9) ? 7'h40 : glyph(nib);
    if (lz && idx > 0 && sh == 16'h0) seg = 7'h00;
    fs  = (kk % FR) == 0;
    if (blk) return {7'h00, 1'b0, 4'h0, fs};
    return {seg, dsh[0], 4'(1 << idx), fs};
  endfunction

  task automatic step(input bit rst);
    logic [12:0] eh, ed;
    reset = rst;
    @(posedge clk);
    #1;
    eh = model(rst, k, blank, lzb_en, 1'b0);
    ed = model(rst, k, blank, lzb_en, 1'b1);
    checks += 3;
    assert ({seg_h, dp_h, en_h, fs_h} === eh) else begin
      errors++;
      $error("FAIL hex k=%0d got %h expected %h", k, {seg_h, dp_h, en_h, fs_h}, eh);
    end
    assert ({seg_d, dp_d, en_d, fs_d} === ed) else begin
      errors++;
      $error("FAIL dec k=%0d got %h expected %h", k, {seg_d, dp_d, en_d, fs_d}, ed);
    end
    assert ({seg_a, dp_a, en_a, fs_a} === (eh ^ AL_MASK)) else begin
      errors++;
      $error("FAIL active_low k=%0d got %h expected %h", k, {seg_a, dp_a, en_a, fs_a}, eh ^ AL_MASK);
    end
    if (rst) begin
      lq.delete();
      k = 0;
    end else begin
      if (load) lq.push_back('{k, value, dp});
      k++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    step(1'b0);
    load  = 1'b0;
  endtask

  task automatic run_to_phase(input int ph);
    while (k % FR != ph) step(1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    value  = '0;
    dp     = '0;
    load   = 1'b0;
    lzb_en = 1'b0;
    blank  = 1'b0;

    // Reset values at the pins
    step(1'b1);
    step(1'b1);

    // Free scan of zero value
    run(FR);

    // Mid-frame load waits for the boundary
    run_to_phase(5);
    load_once(16'h12AF, 4'b0101);
    run(2 * FR);

    // Two loads in one frame: only the later one is shown
    run_to_phase(3);
    load_once(16'h1111, 4'b0011);
    run(4);
    load_once(16'h2222, 4'b1000);
    run(2 * FR);

    // Load on the wrap terminal cycle is shown from the next digit 0
    run_to_phase(FR - 1);
    load_once(16'h3C5E, 4'b1111);
    run(FR + 2);

    // Leading-zero blanking with dash on the decimal instance
    run_to_phase(7);
    load_once(16'h00A5, 4'b0100);
    lzb_en = 1'b1;
    run(2 * FR);
    lzb_en = 1'b0;
    run(4);

    // Six-cycle blank pulse mid-scan
    run_to_phase(6);
    blank = 1'b1;
    run(6);
    blank = 1'b0;
    run(FR);

    // Reset mid-frame discards a pending load
    run_to_phase(6);
    load_once(16'h9999, 4'b1111);
    run(2);
    step(1'b1);
    run(FR + 3);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      value = 16'($urandom);
      dp    = 4'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
      if ($urandom_range(0, 9) == 0)  blank  = ~blank;
      if ($urandom_range(0, 299) == 0) step(1'b1);
      else                             step(1'b0);
    end
    load  = 1'b0;
    blank = 1'b0;
    run(FR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
